poly_ntt_seq: RTL and testbench

Butterfly scheduler for the Dilithium polynomial NTT engine. It sits between the APB command decode (command word at offset 0xFFFC) and the butterfly datapath / 4-bank coefficient RAM. On a start command it generates the full operation stream, one operation per handshake, as coefficient index pairs plus a zeta table index:

- forward NTT: 8 Cooley-Tukey layers;
- inverse NTT: 8 Gentleman-Sande layers followed by a 256-coefficient scaling pass.

Between layers it enforces a write-back barrier, and it raises the completion interrupt when the stream has fully drained.

---
 rtl/poly_ntt_seq.sv | 204 ++++++++++++++++++++
 tb/tb_poly_ntt_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_ntt_seq.sv
// Butterfly scheduler for the Dilithium NTT engine: streams CT/GS butterflies
// and the INTT scaling pass, with a write-back barrier between layers.
module poly_ntt_seq #(
  parameter int MAX_OUT = 16
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       irq_clr,
  input  logic       bf_ready,
  input  logic       wb_done,
  output logic       bf_valid,
  output logic [1:0] bf_op,
  output logic [7:0] bf_idx_a,
  output logic [7:0] bf_idx_b,
  output logic [7:0] bf_zeta_idx,
  output logic       bf_zeta_neg,
  output logic       busy,
  output logic [3:0] layer,
  output logic       done_irq,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_SCALE, S_SDRAIN, S_DONE
  } state_t;

  localparam logic [5:0] MAX_OUT_C = 6'(MAX_OUT);

  state_t     state_q, state_d;
  logic       intt_q, intt_d;
  logic [3:0] layer_q, layer_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] outst_q, outst_d;
  logic       valid_q, valid_d;
  logic [1:0] op_q, op_d;
  logic [7:0] idx_a_q, idx_a_d;
  logic [7:0] idx_b_q, idx_b_d;
  logic [7:0] zeta_q, zeta_d;
  logic       neg_q, neg_d;
  logic       irq_q, irq_d;
  logic       err_q, err_d;

  logic       hs;
  logic [2:0] sh;
  logic [7:0] c7, mask, grp;

  assign hs = valid_q & bf_ready;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    intt_d  = intt_q;
    layer_d = layer_q;
    cnt_d   = cnt_q;
    irq_d   = irq_q;
    err_d   = err_q;

    if (irq_clr) irq_d = 1'b0;
    if (start && state_q != S_IDLE) err_d = 1'b1;
    if (wb_done && outst_q == 6'd0) err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start && (mode == 2'b01 || mode == 2'b10)) begin
          state_d = S_ISSUE;
          intt_d  = (mode == 2'b10);
          layer_d = 4'd0;
          cnt_d   = 8'd0;
          irq_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          if (cnt_q == 8'd127) state_d = S_DRAIN;
          else                 cnt_d   = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (outst_q == 6'd0) begin
          if (layer_q < 4'd7) begin
            state_d = S_ISSUE;
            layer_d = layer_q + 4'd1;
            cnt_d   = 8'd0;
          end else if (intt_q) begin
            state_d = S_SCALE;
            layer_d = 4'd8;
            cnt_d   = 8'd0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SCALE: begin
        if (hs) begin
          if (cnt_q == 8'd255) state_d = S_SDRAIN;
          else                 cnt_d   = cnt_q + 8'd1;
        end
      end
      S_SDRAIN: begin
        if (outst_q == 6'd0) state_d = S_DONE;
      end
      S_DONE: begin
        // Set after the clear so a coincident irq_clr loses.
        irq_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    if (hs && !wb_done)                           outst_d = outst_q + 6'd1;
    else if (!hs && wb_done && outst_q != 6'd0)   outst_d = outst_q - 6'd1;
  end

  // Payload is computed from the next counters and registered, so a stalled
  // operation keeps its counters and therefore its payload.
  always_comb begin
    sh   = intt_d ? layer_d[2:0] : (3'd7 - layer_d[2:0]);
    c7   = {1'b0, cnt_d[6:0]};
    mask = (8'd1 << sh) - 8'd1;
    grp  = c7 >> sh;

    op_d    = op_q;
    idx_a_d = idx_a_q;
    idx_b_d = idx_b_q;
    zeta_d  = zeta_q;
    neg_d   = neg_q;
    valid_d = 1'b0;

    if (state_d == S_SCALE) begin
      op_d    = 2'd2;
      idx_a_d = cnt_d;
      idx_b_d = cnt_d;
      zeta_d  = 8'd0;
      neg_d   = 1'b0;
      valid_d = (outst_d < MAX_OUT_C);
    end else if (state_d == S_ISSUE) begin
      // Insert a zero at bit position sh: group bits move up, offset stays.
      idx_a_d = ((c7 & ~mask) << 1) | (c7 & mask);
      idx_b_d = idx_a_d | (8'd1 << sh);
      if (intt_d) begin
        op_d   = 2'd1;
        neg_d  = 1'b1;
        zeta_d = 8'((9'd256 >> layer_d[2:0]) - 9'd1 - {1'b0, grp});
      end else begin
        op_d   = 2'd0;
        neg_d  = 1'b0;
        zeta_d = (8'd1 << layer_d[2:0]) + grp;
      end
      valid_d = (outst_d < MAX_OUT_C);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= S_IDLE;
      intt_q  <= 1'b0;
      layer_q <= 4'd0;
      cnt_q   <= 8'd0;
      outst_q <= 6'd0;
      valid_q <= 1'b0;
      op_q    <= 2'd0;
      idx_a_q <= 8'd0;
      idx_b_q <= 8'd0;
      zeta_q  <= 8'd0;
      neg_q   <= 1'b0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      intt_q  <= intt_d;
      layer_q <= layer_d;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
      zeta_q  <= zeta_d;
      neg_q   <= neg_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
    end
  end

  assign bf_valid    = valid_q;
  assign bf_op       = op_q;
  assign bf_idx_a    = idx_a_q;
  assign bf_idx_b    = idx_b_q;
  assign bf_zeta_idx = zeta_q;
  assign bf_zeta_neg = neg_q;
  assign busy        = (state_q != S_IDLE);
  assign layer       = layer_q;
  assign done_irq    = irq_q;
  assign err         = err_q;

endmodule

// File: tb/tb_poly_ntt_seq.sv
// Scoreboard bench for poly_ntt_seq: the reference op stream comes from the
// textbook Dilithium NTT/INTT loop nests.
module tb_poly_ntt_seq;

  localparam int MAX_OUT = 4;

  logic       pclk = 1'b0, presetn = 1'b0, start = 1'b0, irq_clr = 1'b0;
  logic       bf_ready = 1'b0, wb_done = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       bf_valid, bf_zeta_neg, busy, done_irq, err;
  logic [1:0] bf_op;
  logic [7:0] bf_idx_a, bf_idx_b, bf_zeta_idx;
  logic [3:0] layer;

  poly_ntt_seq #(.MAX_OUT(MAX_OUT)) dut (
    .pclk(pclk), .presetn(presetn), .start(start), .mode(mode),
    .irq_clr(irq_clr), .bf_ready(bf_ready), .wb_done(wb_done),
    .bf_valid(bf_valid), .bf_op(bf_op), .bf_idx_a(bf_idx_a),
    .bf_idx_b(bf_idx_b), .bf_zeta_idx(bf_zeta_idx), .bf_zeta_neg(bf_zeta_neg),
    .busy(busy), .layer(layer), .done_irq(done_irq), .err(err)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] word;
    bit          first;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] hs_log[$];
  int          pending[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, run_hs = 0, tb_out = 0;
  bit          bp_en = 0, wb_hold = 0, rel_one = 0, spur_req = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [31:0] mk(int op, int a, int b, int z, int neg, int lay);
    return {1'b0, 2'(op), 8'(a), 8'(b), 8'(z), 1'(neg), 4'(lay)};
  endfunction

  function automatic void push(int op, int a, int b, int z, int neg, int lay, bit first);
    exp_t e;
    e.word  = mk(op, a, b, z, neg, lay);
    e.first = first;
    exp_q.push_back(e);
  endfunction

  function automatic void push_ntt();
    int k = 0;
    for (int l = 0; l < 8; l++) begin
      int len = 128 >> l;
      for (int st = 0; st < 256; st += 2 * len) begin
        k++;
        for (int j = st; j < st + len; j++) push(0, j, j + len, k, 0, l, j == 0);
      end
    end
  endfunction

  function automatic void push_intt();
    int k = 256;
    for (int l = 0; l < 8; l++) begin
      int len = 1 << l;
      for (int st = 0; st < 256; st += 2 * len) begin
        k--;
        for (int j = st; j < st + len; j++) push(1, j, j + len, k, 1, l, j == 0);
      end
    end
    for (int j = 0; j < 256; j++) push(2, j, j, 0, 0, 8, j == 0);
  endfunction

  function automatic logic [31:0] log_at(int i);
    return (hs_log.size() > i) ? hs_log[i] : 32'hFFFF_FFFF;
  endfunction

  // Stimulus drivers: ready pattern and write-back pulses, just after the edge.
  always @(posedge pclk) begin
    cyc++;
    #1;
    bf_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    wb_done  = 1'b0;
    if (spur_req) begin
      wb_done  = 1'b1;
      spur_req = 0;
    end else if (rel_one && pending.size() > 0) begin
      void'(pending.pop_front());
      wb_done = 1'b1;
      rel_one = 0;
    end else if (!wb_hold && pending.size() > 0 && pending[0] <= cyc) begin
      void'(pending.pop_front());
      wb_done = 1'b1;
    end
  end

  // Monitor: sees what the next rising edge will consume.
  always @(negedge pclk) begin
    logic [31:0] cur;
    exp_t        e;
    cur = {1'b0, bf_op, bf_idx_a, bf_idx_b, bf_zeta_idx, bf_zeta_neg, layer};
    if (!presetn) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bf_valid), 32'd1);
        check("stall_payload", cur, prev_word);
      end
      if (bf_valid) check("max_out", 32'(tb_out < MAX_OUT), 32'd1);
      if (bf_valid && bf_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_op", cur, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("op%0d", run_hs), cur, e.word);
          if (e.first) check("barrier", 32'(tb_out), 32'd0);
        end
        hs_log.push_back(cur);
        run_hs++;
        pending.push_back(cyc + 3);
        if (!wb_done) tb_out++;
      end else if (wb_done && tb_out > 0) begin
        tb_out--;
      end
      prev_stall = bf_valid && !bf_ready;
      prev_word  = cur;
    end
  end

  task automatic do_start(input logic [1:0] m);
    @(posedge pclk); #1;
    mode  = m;
    start = 1'b1;
    @(posedge pclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_irq && n < budget) begin
      @(negedge pclk);
      n++;
    end
    check("done_irq", 32'(done_irq), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic new_run();
    run_hs = 0;
    hs_log.delete();
  endtask

  initial begin
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_valid", 32'(bf_valid), 32'd0);
    check("rst_op", 32'(bf_op), 32'd0);
    check("rst_idx_a", 32'(bf_idx_a), 32'd0);
    check("rst_idx_b", 32'(bf_idx_b), 32'd0);
    check("rst_zeta", 32'(bf_zeta_idx), 32'd0);
    check("rst_neg", 32'(bf_zeta_neg), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_layer", 32'(layer), 32'd0);
    check("rst_irq", 32'(done_irq), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge pclk); #1;
    presetn = 1'b1;

    // Illegal command code is ignored without error.
    do_start(2'b11);
    repeat (3) @(negedge pclk);
    check("bad_mode_busy", 32'(busy), 32'd0);
    check("bad_mode_valid", 32'(bf_valid), 32'd0);
    check("bad_mode_err", 32'(err), 32'd0);

    // Forward NTT, no backpressure.
    new_run();
    push_ntt();
    do_start(2'b01);
    @(negedge pclk);
    check("ntt_busy_n1", 32'(busy), 32'd1);
    check("ntt_valid_n1", 32'(bf_valid), 32'd1);
    wait_done(6000);
    check("ntt_hs", 32'(run_hs), 32'd1024);
    check("ntt_first", log_at(0), mk(0, 0, 128, 1, 0, 0));
    check("ntt_l1_c64", log_at(192), mk(0, 128, 192, 3, 0, 1));
    check("ntt_last", log_at(1023), mk(0, 254, 255, 255, 0, 7));
    check("ntt_layer", 32'(layer), 32'd7);
    check("ntt_drained", 32'(exp_q.size()), 32'd0);
    @(posedge pclk); #1;
    irq_clr = 1'b1;
    @(posedge pclk); #1;
    irq_clr = 1'b0;
    @(negedge pclk);
    check("irq_clr", 32'(done_irq), 32'd0);

    // Inverse NTT under random backpressure, with a start while busy.
    bp_en = 1;
    new_run();
    push_intt();
    do_start(2'b10);
    repeat (40) @(posedge pclk);
    do_start(2'b01);
    @(negedge pclk);
    check("busy_start_err", 32'(err), 32'd1);
    wait_done(8000);
    check("intt_hs", 32'(run_hs), 32'd1280);
    check("intt_first", log_at(0), mk(1, 0, 1, 255, 1, 0));
    check("intt_l7", log_at(896), mk(1, 0, 128, 1, 1, 7));
    check("scale_first", log_at(1024), mk(2, 0, 0, 0, 0, 8));
    check("scale_last", log_at(1279), mk(2, 255, 255, 0, 0, 8));
    check("intt_layer", 32'(layer), 32'd8);
    check("intt_drained", 32'(exp_q.size()), 32'd0);
    bp_en = 0;

    // In-flight limit with write-backs withheld.
    wb_hold = 1;
    new_run();
    push_ntt();
    do_start(2'b01);
    repeat (12) @(negedge pclk);
    check("start_clears_irq", 32'(done_irq), 32'd0);
    check("max_out_issues", 32'(run_hs), 32'd4);
    check("max_out_valid", 32'(bf_valid), 32'd0);
    rel_one = 1;
    repeat (6) @(negedge pclk);
    check("release_one_issues", 32'(run_hs), 32'd5);
    check("release_one_valid", 32'(bf_valid), 32'd0);
    wb_hold = 0;

    // Reset in the middle of layer 3.
    begin
      int n = 0;
      while (layer != 4'd3 && n < 4000) begin
        @(negedge pclk);
        n++;
      end
      check("reach_layer3", 32'(layer), 32'd3);
    end
    @(posedge pclk); #1;
    presetn = 1'b0;
    exp_q.delete();
    pending.delete();
    rel_one = 0;
    @(negedge pclk);
    check("mid_rst_valid", 32'(bf_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_layer", 32'(layer), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    tb_out = 0;
    @(posedge pclk); #1;
    presetn = 1'b1;

    // Spurious write-back while idle.
    spur_req = 1;
    repeat (3) @(negedge pclk);
    check("spur_err", 32'(err), 32'd1);
    check("spur_busy", 32'(busy), 32'd0);

    // Fresh NTT after the reset; a wrapped counter would block issue here.
    bp_en = 1;
    new_run();
    push_ntt();
    do_start(2'b01);
    wait_done(8000);
    check("post_rst_first", log_at(0), mk(0, 0, 128, 1, 0, 0));
    check("post_rst_hs", 32'(run_hs), 32'd1024);
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);
    bp_en = 0;

    repeat (2) @(negedge pclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
